subword_store: RTL
==================

SUBWORD_STORE -- requirements
Module: subword_store

Interface
REQ-001 SHALL have parameter OP_SW, default 2'b00, meaning full-word store.
REQ-002 SHALL have parameter OP_SH, default 2'b01, meaning halfword store.
REQ-003 SHALL have parameter OP_SB, default 2'b10, meaning byte store; 2'b11 is illegal.
REQ-004 SHALL have a single clock and a synchronous, active-high reset, as ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port start  in  1  request pulse, sampled only in IDLE.
REQ-006 SHALL have port addr  in  32  byte address of store.
REQ-007 SHALL have port wdata  in  32  store data; sub-word value in low bits.
REQ-008 SHALL have port StoreOp  in  2  store width per REQ-001..003.
REQ-009 SHALL have port busy  out  1  high in every non-IDLE state.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port err  out  1  one-cycle pulse coincident with done on misaligned or illegal request.
REQ-012 SHALL have port mem_addr  out  32  word address {addr_q[31:2],2'b00}.
REQ-013 SHALL have ports mem_rd  out  1, mem_wr  out  1, and mem_wdata  out  32, the memory read request, write request and write word.
REQ-014 SHALL have ports mem_rdata  in  32 and mem_ready  in  1, the read word and the access-complete handshake.

Function
REQ-015 SHALL latch addr, wdata and StoreOp on the clk edge where start=1 in IDLE, and ignore start in all other states.
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, FIN.
REQ-017 SHALL go IDLE->WRITE for aligned OP_SW; IDLE->READ for aligned OP_SH/OP_SB; IDLE->FIN with err flagged for a misaligned or illegal request.
REQ-018 SHALL treat as misaligned OP_SW with addr[1:0]!=0 and OP_SH with addr[0]=1; such requests SHALL generate no memory traffic.
REQ-019 SHALL hold mem_rd=1 in READ until the cycle mem_ready=1, capture mem_rdata on that edge, then enter WRITE.
REQ-020 SHALL hold mem_wr=1 in WRITE with mem_wdata stable until mem_ready=1, then enter FIN.
REQ-021 SHALL assert done (and err if flagged) for exactly one cycle in FIN, then return to IDLE.
REQ-022 SHALL never assert mem_rd and mem_wr in the same cycle.
REQ-023 SHALL form mem_wdata for OP_SW as wdata_q unchanged.
REQ-024 SHALL form mem_wdata for OP_SH (little-endian) as the read word with bits [16h+15:16h] replaced by wdata_q[15:0], h=addr_q[1].
REQ-025 SHALL form mem_wdata for OP_SB as the read word with bits [8k+7:8k] replaced by wdata_q[7:0], k=addr_q[1:0]; all other bits preserved.
REQ-026 SHALL, with mem_ready tied high, take 3 cycles from start to done for OP_SW and 4 cycles for OP_SH/OP_SB.
REQ-027 SHALL tolerate any number of mem_ready-low wait cycles without changing mem_addr or mem_wdata.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, enter IDLE and drive busy, done, err, mem_rd and mem_wr to 0, with mem_addr, mem_wdata and latched registers cleared to 0.
REQ-029 SHALL, on rst asserted mid-operation, abandon the memory access immediately with no done pulse; rst SHALL override a simultaneous start.

Structure
REQ-030 SHALL take the OP_SW/OP_SH/OP_SB encodings from a shared definitions file used also by the control unit.
REQ-031 SHALL place the lane-merge logic in one combinational sub-module named store_merge (inputs old word, data, StoreOp, addr[1:0]; output new word).

Verification
REQ-032 SHALL verify: SW addr=0x100, wdata=0xDEADBEEF, mem_ready=1 -> mem_wr with mem_addr=0x100, mem_wdata=0xDEADBEEF, no mem_rd, done 3 cycles after start.
REQ-033 SHALL verify: SB addr=0x203, wdata=0x000000AA, mem_rdata=0x11223344 -> mem_rd then mem_wr to 0x200 with 0xAA223344, done 4 cycles after start.
REQ-034 SHALL verify: SH addr=0x042, wdata=0x0000BEEF, mem_rdata=0x11223344, mem_ready low 2 cycles in both phases -> mem_wdata=0xBEEF3344, outputs stable while waiting.
REQ-035 SHALL verify: SH addr=0x041 and StoreOp=2'b11 -> done and err pulse together, mem_rd and mem_wr never asserted.
REQ-036 SHALL verify: rst pulsed during READ wait -> next cycle busy=0, mem_rd=0, no done; a following SW completes normally.
REQ-037 SHALL verify: start reasserted while busy -> ignored, exactly one done per accepted request.

Source files
------------

// File: rtl/subword_store_pkg.sv
// -----------------------------------------------------------------------------
// subword_store_pkg
// Shared definitions for the store path: the StoreOp width encodings (also used
// by the control unit), the store FSM state type and a helper that decides
// whether a request is misaligned or carries an illegal width code.
// -----------------------------------------------------------------------------
package subword_store_pkg;

   localparam logic [1:0] SS_OP_SW = 2'b00;
   localparam logic [1:0] SS_OP_SH = 2'b01;
   localparam logic [1:0] SS_OP_SB = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_FIN   = 2'd3
   } store_state_t;

   // A word store needs a word-aligned address and a halfword store an even one.
   // Byte stores are always aligned. Any code outside the three widths is
   // rejected outright.
   function automatic logic bad_request(input logic [1:0] op,
                                        input logic [1:0] addr_lo,
                                        input logic [1:0] op_sw,
                                        input logic [1:0] op_sh,
                                        input logic [1:0] op_sb);
      if (op == op_sw)
         return addr_lo != 2'b00;
      else if (op == op_sh)
         return addr_lo[0];
      else if (op == op_sb)
         return 1'b0;
      else
         return 1'b1;
   endfunction

endpackage

// File: rtl/subword_store_if.sv
// -----------------------------------------------------------------------------
// subword_store_if
// Bundles the request side (start/addr/wdata/StoreOp -> busy/done/err) and the
// word-wide memory side (mem_addr/mem_rd/mem_wr/mem_wdata <- mem_rdata/mem_ready)
// of the sub-word store unit.
//   slave  : view taken by the store unit itself
//   master : view taken by whoever issues stores and models the memory
// -----------------------------------------------------------------------------
interface subword_store_if;

   logic        start;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  StoreOp;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport slave (
      input  start, addr, wdata, StoreOp, mem_rdata, mem_ready,
      output busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
   );

   modport master (
      output start, addr, wdata, StoreOp, mem_rdata, mem_ready,
      input  busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
   );

endinterface

// File: rtl/subword_store_merge.sv
// -----------------------------------------------------------------------------
// store_merge
// Purely combinational lane merge for little-endian sub-word stores.
//   old_word : word previously read from memory
//   data     : store data, sub-word value in the low bits
//   store_op : width code (word / halfword / byte)
//   addr_lo  : byte offset of the store within the word
//   new_word : word to write back
// -----------------------------------------------------------------------------
module store_merge
   import subword_store_pkg::*;
#(
   parameter logic [1:0] OP_SW = SS_OP_SW,
   parameter logic [1:0] OP_SH = SS_OP_SH,
   parameter logic [1:0] OP_SB = SS_OP_SB
) (
   input  logic [31:0] old_word,
   input  logic [31:0] data,
   input  logic [1:0]  store_op,
   input  logic [1:0]  addr_lo,
   output logic [31:0] new_word
);

   // Start from the old word so every lane not targeted by the store is kept.
   // A word store replaces everything; a halfword picks its lane with addr_lo[1];
   // a byte picks its lane with both offset bits.
   always_comb begin
      new_word = old_word;
      if (store_op == OP_SW) begin
         new_word = data;
      end else if (store_op == OP_SH) begin
         if (addr_lo[1])
            new_word[31:16] = data[15:0];
         else
            new_word[15:0]  = data[15:0];
      end else if (store_op == OP_SB) begin
         case (addr_lo)
            2'd0:    new_word[7:0]   = data[7:0];
            2'd1:    new_word[15:8]  = data[7:0];
            2'd2:    new_word[23:16] = data[7:0];
            default: new_word[31:24] = data[7:0];
         endcase
      end
   end

endmodule

// File: rtl/subword_store.sv
// -----------------------------------------------------------------------------
// subword_store
// Performs byte/halfword/word stores against a word-only memory. Word stores are
// written directly; sub-word stores read the containing word, merge the new
// lane(s) in and write the word back. Misaligned or illegal requests finish
// with err and never touch memory.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : request + memory handshake (slave view of subword_store_if)
// -----------------------------------------------------------------------------
module subword_store
   import subword_store_pkg::*;
#(
   parameter logic [1:0] OP_SW = SS_OP_SW,
   parameter logic [1:0] OP_SH = SS_OP_SH,
   parameter logic [1:0] OP_SB = SS_OP_SB
) (
   input  logic            clk,
   input  logic            rst,
   subword_store_if.slave  bus
);

   store_state_t state;
   store_state_t state_nxt;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [1:0]  op_q;
   logic        err_q;
   logic        accept;
   logic        req_bad;
   logic [31:0] merged;

   assign accept  = (state == ST_IDLE) && bus.start;
   assign req_bad = bad_request(bus.StoreOp, bus.addr[1:0], OP_SW, OP_SH, OP_SB);

   // State register. Reset wins over everything, including a start in the
   // same cycle, and drops any memory access in flight.
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic. Word stores skip the read since the whole word is
   // replaced; rejected requests go straight to FIN so they cost no memory
   // cycles. READ and WRITE hold until the memory acknowledges.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (bus.start) begin
               if (req_bad)
                  state_nxt = ST_FIN;
               else if (bus.StoreOp == OP_SW)
                  state_nxt = ST_WRITE;
               else
                  state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (bus.mem_ready)
               state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            if (bus.mem_ready)
               state_nxt = ST_FIN;
         end
         ST_FIN: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Request and read-data capture. The request is only taken in IDLE so that
   // the address and write word cannot move underneath an access, and the read
   // word is taken on the edge the memory acknowledges it.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         op_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            op_q    <= bus.StoreOp;
            err_q   <= req_bad;
         end
         if ((state == ST_READ) && bus.mem_ready)
            rdata_q <= bus.mem_rdata;
      end
   end

   store_merge #(
      .OP_SW (OP_SW),
      .OP_SH (OP_SH),
      .OP_SB (OP_SB)
   ) u_merge (
      .old_word (rdata_q),
      .data     (wdata_q),
      .store_op (op_q),
      .addr_lo  (addr_q[1:0]),
      .new_word (merged)
   );

   // The write word and address come only from registered state, so they hold
   // steady through any number of memory wait cycles.
   assign bus.mem_addr  = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata = merged;

   // Output decode. Read and write strobes come from distinct states, so they
   // can never be high together; err only shows alongside done in FIN.
   always_comb begin
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      bus.err    = 1'b0;
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
      unique case (state)
         ST_IDLE: begin
         end
         ST_READ: begin
            bus.busy   = 1'b1;
            bus.mem_rd = 1'b1;
         end
         ST_WRITE: begin
            bus.busy   = 1'b1;
            bus.mem_wr = 1'b1;
         end
         ST_FIN: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
            bus.err  = err_q;
         end
         default: begin
         end
      endcase
   end

endmodule
